// File: rtl/epochtv1_pkg.sv
// Shared definitions for the Epoch TV-1 video pipeline: raster geometry,
// background fetch FSM states and the render pixel format.
package epochtv1_pkg;

    // Raster geometry shared by the sync generator, sprite and tile pipelines.
    localparam int FIRST_COL_RENDER = 28;
    localparam int FIRST_ROW_RENDER = 21;
    localparam int TILE_COLS        = 24;
    localparam int TILE_ROWS        = 14;
    localparam int TILE_W           = 8;
    localparam int TILE_H           = 16;
    localparam int RENDER_COLS      = TILE_COLS * TILE_W;
    localparam int RENDER_ROWS      = TILE_ROWS * TILE_H;

    // 9-bit forms matching the ROW/COL counter width.
    localparam logic [8:0] COL_RENDER_FIRST = 9'(FIRST_COL_RENDER);
    localparam logic [8:0] COL_RENDER_END   = 9'(FIRST_COL_RENDER + RENDER_COLS);
    localparam logic [8:0] ROW_RENDER_FIRST = 9'(FIRST_ROW_RENDER);
    localparam logic [8:0] ROW_RENDER_END   = 9'(FIRST_ROW_RENDER + RENDER_ROWS);

    // Fetching runs one tile ahead of the beam, so its column origin sits
    // one tile width to the left of the first visible column.
    localparam logic [8:0] COL_FETCH_FIRST  = 9'(FIRST_COL_RENDER - TILE_W);
    localparam logic [5:0] SLOT_LAST        = 6'(TILE_COLS - 1);

    // Background fetch FSM.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MAP   = 3'd1,
        S_CHR   = 3'd2,
        S_LATCH = 3'd3,
        S_DONE  = 3'd4
    } bg_state_e;

    // Pixel presented to the render/priority mux.
    typedef struct packed {
        logic       opaque;
        logic [3:0] colour;
    } bg_px_t;

    localparam bg_px_t PX_TRANSPARENT = '0;

    // Build a pixel; transparent pixels always carry colour 0 so the
    // priority mux can compare whole words.
    function automatic bg_px_t make_px(input logic opaque, input logic [3:0] colour);
        bg_px_t px;
        px = PX_TRANSPARENT;
        if (opaque) begin
            px.opaque = 1'b1;
            px.colour = colour;
        end
        return px;
    endfunction

    // Half-open range test on a 9-bit raster coordinate.
    function automatic logic in_span(input logic [8:0] v, input logic [8:0] lo,
                                     input logic [8:0] hi_excl);
        return (v >= lo) && (v < hi_excl);
    endfunction

endpackage

// File: rtl/epochtv1_bg_shifter.sv
// 8-bit pattern shift register plus registered pixel output. Bit 7 is the
// leftmost pixel of a tile row. Shared with the high-resolution plane.
module epochtv1_bg_shifter
    import epochtv1_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ce,
    input  logic       i_load,
    input  logic [7:0] i_load_data,
    input  logic       i_render_px,
    input  logic       i_bg_en,
    input  logic [3:0] i_clr_fg,
    output bg_px_t     o_px
);

    logic [7:0] r_sr;
    bg_px_t     r_px;
    logic       w_opaque;

    // The pixel for the current column is taken from bit 7 before this CE's
    // shift/load, giving a one-CE output latency.
    assign w_opaque = i_render_px & i_bg_en & r_sr[7];

    // Load a fresh tile pattern at the tile boundary, otherwise shift left.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sr <= 8'h00;
        end else if (i_ce) begin
            if (i_load) begin
                r_sr <= i_load_data;
            end else begin
                r_sr <= {r_sr[6:0], 1'b0};
            end
        end
    end

    // Registered pixel output, aligned with the sprite line-buffer pixel.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_px <= PX_TRANSPARENT;
        end else if (i_ce) begin
            r_px <= make_px(w_opaque, i_clr_fg);
        end
    end

    assign o_px = r_px;

endmodule

// File: rtl/epochtv1_bg_fetch.sv
// Background tile-plane pipeline: walks the background map and character
// ROM one tile ahead of the beam and emits one background pixel per CE.
//
// BGM access: an address presented in S_MAP is served on a CE where STALL
// is low; its data is valid at the following CE. While STALL is high the
// CPU owns the map memory and the FSM simply retries. CHR is never
// arbitrated; its data is valid at the CE after CHR_A is registered.
module epochtv1_bg_fetch
    import epochtv1_pkg::*;
(
    input  logic       CLK,
    input  logic       RESB,
    input  logic       CE,
    input  logic [8:0] ROW,
    input  logic [8:0] COL,
    input  logic       BG_EN,
    input  logic [3:0] CLR_FG,
    input  logic       STALL,
    output logic [8:0] BGM_A,
    input  logic [7:0] BGM_D,
    output logic [9:0] CHR_A,
    input  logic [7:0] CHR_D,
    output logic [4:0] BG_PX,
    output logic       MISS,
    output logic [2:0] o_dbg_state
);

    // Raster decode.
    logic [8:0] w_ry;
    logic [8:0] w_cx;
    logic [5:0] w_slot;
    logic [2:0] w_phase;
    logic [3:0] w_tile_row;
    logic [2:0] w_line;
    logic [4:0] w_k;
    logic [4:0] w_k_next;
    logic       w_row_vis;
    logic       w_in_win;
    logic       w_next_in_win;
    logic       w_render_px;
    logic       w_phase0;
    logic       w_phase7;
    logic       w_unused;

    // Fetch state.
    bg_state_e  r_state;
    logic [8:0] r_bgm_a;
    logic [9:0] r_chr_a;
    logic [7:0] r_next_pat;
    logic       r_miss;
    bg_px_t     w_px;

    assign w_ry       = ROW - ROW_RENDER_FIRST;
    assign w_cx       = COL - COL_FETCH_FIRST;
    assign w_slot     = w_cx[8:3];
    assign w_phase    = w_cx[2:0];
    assign w_tile_row = w_ry[7:4];
    // Each pattern row is shown on two consecutive lines.
    assign w_line     = w_ry[3:1];
    assign w_k        = w_slot[4:0];
    assign w_k_next   = w_k + 5'd1;

    assign w_row_vis     = in_span(ROW, ROW_RENDER_FIRST, ROW_RENDER_END);
    // Columns left of the fetch origin wrap to large cx and fall outside.
    assign w_in_win      = w_row_vis && (w_slot <= SLOT_LAST);
    assign w_next_in_win = w_row_vis && (w_slot < SLOT_LAST);
    assign w_render_px   = w_row_vis && in_span(COL, COL_RENDER_FIRST, COL_RENDER_END);
    assign w_phase0      = (w_phase == 3'd0);
    assign w_phase7      = (w_phase == 3'd7);

    // Map bit 7, the sign of ry and the line-doubling bit are not needed.
    assign w_unused = ^{BGM_D[7], w_ry[8], w_ry[0]};

    // Tile fetch FSM: map read, pattern read, latch, then wait for the tile
    // boundary. The phase-7 CE always closes the slot, abandoning a fetch
    // that has not latched its pattern yet.
    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB) begin
            r_state    <= S_IDLE;
            r_bgm_a    <= 9'h000;
            r_chr_a    <= 10'h000;
            r_next_pat <= 8'h00;
            r_miss     <= 1'b0;
        end else if (CE) begin
            r_miss <= 1'b0;
            if (w_phase7) begin
                // The shifter takes next_pat on this CE; start the next tile empty.
                r_next_pat <= 8'h00;
                if ((r_state != S_IDLE) && (r_state != S_DONE)) begin
                    r_miss <= 1'b1;
                end
                if (r_state != S_IDLE) begin
                    if (w_next_in_win) begin
                        r_state <= S_MAP;
                        r_bgm_a <= {w_tile_row, w_k_next};
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_in_win && w_phase0) begin
                            r_state <= S_MAP;
                            r_bgm_a <= {w_tile_row, w_k};
                        end
                    end
                    S_MAP: begin
                        if (!STALL) begin
                            r_state <= S_CHR;
                        end
                    end
                    S_CHR: begin
                        r_chr_a <= {BGM_D[6:0], w_line};
                        r_state <= S_LATCH;
                    end
                    S_LATCH: begin
                        r_next_pat <= CHR_D;
                        r_state    <= S_DONE;
                    end
                    S_DONE: begin
                        r_state <= S_DONE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    epochtv1_bg_shifter u_shifter (
        .i_clk       (CLK),
        .i_rst_n     (RESB),
        .i_ce        (CE),
        .i_load      (w_phase7),
        .i_load_data (r_next_pat),
        .i_render_px (w_render_px),
        .i_bg_en     (BG_EN),
        .i_clr_fg    (CLR_FG),
        .o_px        (w_px)
    );

    assign BGM_A       = r_bgm_a;
    assign CHR_A       = r_chr_a;
    assign MISS        = r_miss;
    assign BG_PX       = w_px;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_epochtv1_bg_fetch.sv
// Directed bench for the background tile fetch pipeline. CE runs at half
// the clock rate; each column is one CE followed by one idle clock.
module tb_epochtv1_bg_fetch;
    import epochtv1_pkg::*;

    localparam int NCOL = 240;

    // ---------------- clock / reset ----------------
    logic       CLK = 1'b0;
    logic       RESB = 1'b0;
    logic       CE = 1'b0;
    logic [8:0] ROW = 9'd0;
    logic [8:0] COL = 9'd0;
    logic       BG_EN = 1'b1;
    logic [3:0] CLR_FG = 4'h7;
    logic       STALL = 1'b0;
    logic [8:0] BGM_A;
    logic [7:0] BGM_D = 8'h00;
    logic [9:0] CHR_A;
    logic [7:0] CHR_D;
    logic [4:0] BG_PX;
    logic       MISS;
    logic [2:0] dbg_state;

    always #5 CLK = ~CLK;

    epochtv1_bg_fetch dut (
        .CLK         (CLK),
        .RESB        (RESB),
        .CE          (CE),
        .ROW         (ROW),
        .COL         (COL),
        .BG_EN       (BG_EN),
        .CLR_FG      (CLR_FG),
        .STALL       (STALL),
        .BGM_A       (BGM_A),
        .BGM_D       (BGM_D),
        .CHR_A       (CHR_A),
        .CHR_D       (CHR_D),
        .BG_PX       (BG_PX),
        .MISS        (MISS),
        .o_dbg_state (dbg_state)
    );

    // ---------------- memory models ----------------
    // Map RAM: served only when the CPU does not own it; CPU data otherwise.
    logic [7:0] bgm [512];
    logic [7:0] chr [1024];

    always @(posedge CLK) begin
        if (CE) BGM_D <= STALL ? 8'hEE : bgm[BGM_A];
    end
    assign CHR_D = chr[CHR_A];

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [4:0] exp_q [$];
    logic [4:0] px_at [NCOL];
    logic       miss_at [NCOL];
    logic       stall_col [NCOL];
    int nz_cnt, miss_cnt, a_chg;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic ce_step(input logic [8:0] row, input logic [8:0] col, input logic stall);
        ROW = row; COL = col; STALL = stall; CE = 1'b1;
        @(posedge CLK); #1;
        CE = 1'b0; STALL = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic sweep_row(input logic [8:0] row);
        logic [8:0] prev_a;
        nz_cnt = 0; miss_cnt = 0; a_chg = 0;
        prev_a = BGM_A;
        for (int c = 0; c < NCOL; c++) begin
            ce_step(row, 9'(c), stall_col[c]);
            px_at[c]   = BG_PX;
            miss_at[c] = MISS;
            if (BG_PX != 5'h00) nz_cnt++;
            if (MISS) miss_cnt++;
            if (BGM_A != prev_a) a_chg++;
            prev_a = BGM_A;
        end
    endtask

    // Expected pixels of one displayed tile, leftmost pixel = pattern bit 7.
    task automatic push_tile(input logic [7:0] pat, input logic [3:0] clr);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(pat[7 - i] ? {1'b1, clr} : 5'h00);
        end
    endtask

    task automatic check_span(input string tag, input int lo, input int n);
        logic [4:0] e;
        for (int c = lo; c < lo + n; c++) begin
            e = exp_q.pop_front();
            check_eq($sformatf("%s px c%0d", tag, c), int'(px_at[c]), int'(e));
        end
    endtask

    function automatic int count_nz(input int lo, input int hi);
        int n;
        n = 0;
        for (int c = lo; c <= hi; c++) if (px_at[c] != 5'h00) n++;
        return n;
    endfunction

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        int nz_tot, miss_tot, chg_tot;
        for (int i = 0; i < 512; i++) bgm[i] = 8'h00;
        for (int i = 0; i < 1024; i++) chr[i] = 8'h00;
        for (int i = 0; i < NCOL; i++) stall_col[i] = 1'b0;

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        check_eq("rst BG_PX", int'(BG_PX), 0);
        check_eq("rst BGM_A", int'(BGM_A), 0);
        check_eq("rst CHR_A", int'(CHR_A), 0);
        check_eq("rst MISS", int'(MISS), 0);
        check_eq("rst state", int'(dbg_state), int'(S_IDLE));
        RESB = 1'b1;
        @(posedge CLK); #1;

        // Row 21, tile 0 = code 5, pattern A5
        bgm[0] = 8'h05; chr[10'h028] = 8'hA5;
        sweep_row(9'd21);
        exp_q.push_back(5'h00);
        push_tile(8'hA5, 4'h7);
        exp_q.push_back(5'h00);
        check_span("r21", 27, 10);
        check_eq("r21 nz", nz_cnt, 4);
        check_eq("r21 miss", miss_cnt, 0);

        // Row 23: line 1 uses CHR 0x029
        chr[10'h029] = 8'hFF;
        sweep_row(9'd23);
        push_tile(8'hFF, 4'h7);
        check_span("r23", 28, 8);
        check_eq("r23 nz", nz_cnt, 8);

        // Stalls: short stall in slot 1, deadline miss in slot 2, bit 7 of map ignored in tile 3
        bgm[1] = 8'h05; bgm[2] = 8'h05; bgm[3] = 8'h85;
        for (int c = 28; c <= 30; c++) stall_col[c] = 1'b1;
        for (int c = 36; c <= 42; c++) stall_col[c] = 1'b1;
        sweep_row(9'd21);
        for (int i = 0; i < NCOL; i++) stall_col[i] = 1'b0;
        push_tile(8'hA5, 4'h7);
        push_tile(8'hA5, 4'h7);
        push_tile(8'h00, 4'h7);
        push_tile(8'hA5, 4'h7);
        check_span("stall", 28, 32);
        check_eq("stall miss count", miss_cnt, 1);
        check_eq("stall miss c35", int'(miss_at[35]), 0);
        check_eq("stall miss c43", int'(miss_at[43]), 1);

        // Full pattern map, plane disabled then enabled
        for (int k = 0; k < 24; k++) bgm[k] = 8'h05;
        chr[10'h028] = 8'hFF;
        BG_EN = 1'b0;
        sweep_row(9'd21);
        check_eq("bgen0 nz", nz_cnt, 0);
        check_eq("bgen0 miss", miss_cnt, 0);
        BG_EN = 1'b1;
        sweep_row(9'd21);
        check_eq("full nz", nz_cnt, 192);
        check_eq("full c27", int'(px_at[27]), 0);
        check_eq("full c28", int'(px_at[28]), 'h17);
        check_eq("full c219", int'(px_at[219]), 'h17);
        check_eq("full c220", int'(px_at[220]), 0);

        // Non-visible rows: no fetches, no pixels, no misses
        nz_tot = 0; miss_tot = 0; chg_tot = 0;
        for (int r = 0; r <= 20; r++) begin
            sweep_row(9'(r));
            nz_tot += nz_cnt; miss_tot += miss_cnt; chg_tot += a_chg;
        end
        sweep_row(9'd245);
        nz_tot += nz_cnt; miss_tot += miss_cnt; chg_tot += a_chg;
        sweep_row(9'd261);
        nz_tot += nz_cnt; miss_tot += miss_cnt; chg_tot += a_chg;
        check_eq("blank nz", nz_tot, 0);
        check_eq("blank miss", miss_tot, 0);
        check_eq("blank BGM_A changes", chg_tot, 0);

        // Last visible row: tile row 13, line 7, first and last tiles
        CLR_FG = 4'hC;
        bgm[13 * 32 + 0] = 8'h05; bgm[13 * 32 + 23] = 8'h05;
        chr[10'h02F] = 8'hC3;
        sweep_row(9'd244);
        push_tile(8'hC3, 4'hC);
        check_span("r244 first", 28, 8);
        push_tile(8'hC3, 4'hC);
        check_span("r244 last", 212, 8);
        check_eq("r244 nz", nz_cnt, 8);
        check_eq("r244 BGM_A", int'(BGM_A), 13 * 32 + 23);
        check_eq("r244 CHR_A", int'(CHR_A), 'h2F);
        CLR_FG = 4'h7;

        // Reset mid-frame at col 100 of row 50 (tile row 1, line 6)
        for (int k = 0; k < 24; k++) bgm[32 + k] = 8'h05;
        chr[10'h02E] = 8'hFF;
        for (int c = 0; c < 100; c++) begin
            ce_step(9'd50, 9'(c), 1'b0);
            px_at[c] = BG_PX;
        end
        check_eq("r50 c99", int'(px_at[99]), 'h17);
        RESB = 1'b0;
        #1;
        check_eq("midrst BG_PX", int'(BG_PX), 0);
        check_eq("midrst BGM_A", int'(BGM_A), 0);
        check_eq("midrst CHR_A", int'(CHR_A), 0);
        check_eq("midrst MISS", int'(MISS), 0);
        check_eq("midrst state", int'(dbg_state), int'(S_IDLE));
        ce_step(9'd50, 9'd100, 1'b0);
        px_at[100] = BG_PX;
        RESB = 1'b1;
        for (int c = 101; c < NCOL; c++) begin
            ce_step(9'd50, 9'(c), 1'b0);
            px_at[c] = BG_PX;
        end
        check_eq("post-rst nz 100..115", count_nz(100, 115), 0);
        check_eq("post-rst c116", int'(px_at[116]), 'h17);
        check_eq("post-rst nz 116..219", count_nz(116, 219), 104);
        check_eq("post-rst c220", int'(px_at[220]), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
